// File: rtl/if_prefetch.sv
// Instruction prefetcher: one outstanding memory request feeding a small
// in-order instruction queue, with redirect (flush/refetch) support.
module if_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] jpc,
  input  logic        if_pc_jump,
  input  logic        if_bubble,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_data,
  output logic        ins_valid,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  output logic [31:0] npc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t          state_reg, state_next;
  logic [31:0]     fetch_pc_reg, fetch_pc_next;
  logic [31:0]     im_addr_reg, im_addr_next;
  logic            im_req_reg, im_req_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;

  logic            busy, remains, push, pop, issue;

  logic [DEPTH-1:0][31:0] ins_ent;
  logic [DEPTH-1:0][31:0] pc_ent;

  always_comb begin
    busy    = (state_reg != IDLE);
    // A request survives the edge only if it is live and not completing now.
    remains = busy && !im_ack;
    push    = (state_reg == WAIT) && im_ack && !if_pc_jump;
    pop     = (count_reg != '0) && !if_bubble && !if_pc_jump;

    count_next    = count_reg;
    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;
    fetch_pc_next = fetch_pc_reg;

    if (if_pc_jump) begin
      count_next    = '0;
      rd_ptr_next   = '0;
      wr_ptr_next   = '0;
      fetch_pc_next = jpc;
    end else begin
      count_next  = count_reg + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
      rd_ptr_next = rd_ptr_reg + {{(PW-1){1'b0}}, pop};
      wr_ptr_next = wr_ptr_reg + {{(PW-1){1'b0}}, push};
      if (push) begin
        fetch_pc_next = fetch_pc_reg + 32'd4;
      end
    end

    // Only issue when the slot being requested is guaranteed a home in the queue.
    issue = !remains && (count_next < CW'(DEPTH));

    im_req_next  = issue || remains;
    im_addr_next = issue ? fetch_pc_next : im_addr_reg;

    if (issue) begin
      state_next = WAIT;
    end else if (remains) begin
      state_next = (state_reg == WAIT && if_pc_jump) ? DISCARD : state_reg;
    end else begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      im_addr_reg  <= RESET_PC;
      im_req_reg   <= 1'b0;
      count_reg    <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      im_addr_reg  <= im_addr_next;
      im_req_reg   <= im_req_next;
      count_reg    <= count_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
    end
  end

  // Queue storage is reset so the head reads as zero straight out of reset.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [31:0] ins_reg;
      logic [31:0] pc_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ins_reg <= '0;
          pc_reg  <= '0;
        end else if (push && (wr_ptr_reg == PW'(gi))) begin
          ins_reg <= im_data;
          pc_reg  <= im_addr_reg;
        end
      end

      assign ins_ent[gi] = ins_reg;
      assign pc_ent[gi]  = pc_reg;
    end
  endgenerate

  assign im_req    = im_req_reg;
  assign im_addr   = im_addr_reg;
  assign ins_valid = (count_reg != '0);
  assign ins       = ins_ent[rd_ptr_reg];
  assign ins_pc    = pc_ent[rd_ptr_reg];
  assign npc       = pc_ent[rd_ptr_reg] + 32'd4;

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: directed scenarios plus random traffic, checked
// against a queue-based reference model of the fetch/queue rules.
module tb_if_prefetch;

  localparam logic [31:0] RESET_PC = 32'h00000000;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] jpc = '0;
  logic        if_pc_jump = 1'b0;
  logic        if_bubble = 1'b0;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack = 1'b0;
  logic [31:0] im_data = '0;
  logic        ins_valid;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic [31:0] npc;

  if_prefetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .jpc(jpc), .if_pc_jump(if_pc_jump),
    .if_bubble(if_bubble), .im_req(im_req), .im_addr(im_addr),
    .im_ack(im_ack), .im_data(im_data), .ins_valid(ins_valid),
    .ins(ins), .ins_pc(ins_pc), .npc(npc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of {pc, word}, plus request bookkeeping.
  logic [63:0] q[$];
  logic [31:0] m_fetch;
  logic [31:0] m_addr;
  bit          m_pend;
  bit          m_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".im_req"}, {31'd0, im_req}, {31'd0, m_pend});
    chk({tag, ".im_addr"}, im_addr, m_addr);
    chk({tag, ".ins_valid"}, {31'd0, ins_valid}, {31'd0, q.size() > 0});
    if (q.size() > 0) begin
      chk({tag, ".ins"}, ins, q[0][31:0]);
      chk({tag, ".ins_pc"}, ins_pc, q[0][63:32]);
      chk({tag, ".npc"}, npc, q[0][63:32] + 32'd4);
    end
    $display("%0t %s req=%b addr=%h valid=%b pc=%h ins=%h qsize=%0d",
             $time, tag, im_req, im_addr, ins_valid, ins_pc, ins, q.size());
  endtask

  task automatic step(input string tag, input bit jmp, input logic [31:0] jt,
                      input bit bub, input bit ack, input logic [31:0] dat);
    bit done;
    if_pc_jump = jmp;
    jpc        = jt;
    if_bubble  = bub;
    im_ack     = ack;
    im_data    = dat;
    @(posedge clk);
    done = m_pend && ack;
    if (jmp) begin
      q.delete();
      m_fetch = jt;
    end else begin
      if (!bub && q.size() > 0) void'(q.pop_front());
      if (done && !m_drop) begin
        q.push_back({m_addr, dat});
        m_fetch = m_fetch + 32'd4;
      end
    end
    if (done) m_pend = 0;
    if (jmp && m_pend) m_drop = 1;
    if (!m_pend) begin
      m_drop = 0;
      if (q.size() < DEPTH) begin
        m_pend = 1;
        m_addr = m_fetch;
      end
    end
    #1;
    compare_all(tag);
  endtask

  // Asynchronous reset applied mid-cycle; outputs are checked before any edge.
  task automatic do_reset();
    #3;
    if_pc_jump = 0; if_bubble = 0; im_ack = 0;
    rst = 1'b0;
    #1;
    q.delete();
    m_fetch = RESET_PC; m_addr = RESET_PC; m_pend = 0; m_drop = 0;
    chk("rst.im_req", {31'd0, im_req}, 32'd0);
    chk("rst.ins_valid", {31'd0, ins_valid}, 32'd0);
    chk("rst.im_addr", im_addr, RESET_PC);
    chk("rst.ins", ins, 32'd0);
    chk("rst.ins_pc", ins_pc, 32'd0);
    chk("rst.npc", npc, 32'd4);
    $display("%0t reset asserted req=%b valid=%b addr=%h", $time, im_req, ins_valid, im_addr);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bit jmp, bub, ack;
    logic [31:0] jt;

    // Sequential streaming, ack every cycle, data equals address.
    do_reset();
    for (int i = 0; i < 8; i++) step("stream", 0, 0, 0, 1, m_addr);
    chk("stream.first_addr_seq", ins_pc + 32'd4, npc);

    // Hold bubble: queue fills to DEPTH then requests stop; release drains in order.
    do_reset();
    for (int i = 0; i < 8; i++) step("bubble_fill", 0, 0, 1, 1, m_addr);
    chk("bubble_fill.req_off", {31'd0, im_req}, 32'd0);
    chk("bubble_fill.head", ins_pc, 32'h0);
    for (int i = 0; i < 6; i++) step("bubble_drain", 0, 0, 0, 1, m_addr);

    // Redirect while a request is pending without ack.
    do_reset();
    for (int i = 0; i < 5; i++) step("pre_jump", 0, 0, 0, 1, m_addr);
    chk("pre_jump.addr10", im_addr, 32'h10);
    for (int i = 0; i < 3; i++) step("ack_low", 0, 0, 0, 0, 0);
    step("jump_wait", 1, 32'h100, 0, 0, 0);
    chk("jump_wait.addr_held", im_addr, 32'h10);
    step("discard_hold", 0, 0, 0, 0, 0);
    step("discard_ack", 0, 0, 0, 1, 32'hDEADBEEF);
    chk("discard_ack.addr", im_addr, 32'h100);
    step("after_jump", 0, 0, 0, 1, m_addr);
    chk("after_jump.pc", ins_pc, 32'h100);

    // Redirect coincident with ack.
    step("jump_ack", 1, 32'h200, 0, 1, 32'h12345678);
    chk("jump_ack.addr", im_addr, 32'h200);
    for (int i = 0; i < 3; i++) step("post_jump_ack", 0, 0, 0, 1, m_addr);

    // Redirect to the top of the address space: fetch_pc wraps to zero.
    step("jump_wrap", 1, 32'hFFFFFFF8, 0, 1, 0);
    for (int i = 0; i < 4; i++) step("wrap", 0, 0, 0, 1, m_addr ^ 32'h5A5A0000);

    // Reset in WAIT with two queued entries; in-flight response ignored.
    do_reset();
    step("w1", 0, 0, 1, 1, m_addr);
    step("w2", 0, 0, 1, 1, m_addr);
    step("w3", 0, 0, 1, 1, m_addr);
    chk("w3.two_entries", {31'd0, ins_valid}, 32'd1);
    do_reset();
    step("post_rst", 0, 0, 0, 1, 32'hBADBAD00);
    chk("post_rst.addr", im_addr, RESET_PC);

    // Full queue with pops and acks each cycle.
    for (int i = 0; i < 6; i++) step("fill", 0, 0, 1, 1, m_addr);
    for (int i = 0; i < 10; i++) step("full_flow", 0, 0, 0, 1, m_addr);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      jmp = ($urandom_range(0, 15) == 0);
      jt  = $urandom & 32'hFFFFFFFC;
      bub = ($urandom_range(0, 2) == 0);
      ack = $urandom_range(0, 1) == 1;
      step("rand", jmp, jt, bub, ack, $urandom);
      if (i % 150 == 149) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4, the instruction-queue entry count; legal values are powers of two from 2 to 16.
REQ-003 SHALL have port clk  in  1  the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port jpc  in  32  redirect target.
REQ-006 SHALL have port if_pc_jump  in  1  redirect strobe: flush and refetch from jpc.
REQ-007 SHALL have port if_bubble  in  1  downstream stall: head entry is not consumed.
REQ-008 SHALL have port im_req  out  1  instruction-memory request, registered.
REQ-009 SHALL have port im_addr  out  32  request address, registered, stable while im_req=1 and im_ack=0.
REQ-010 SHALL have port im_ack  in  1  request complete; im_data is valid in the same cycle.
REQ-011 SHALL have port im_data  in  32  returned instruction word.
REQ-012 SHALL have port ins_valid  out  1  queue head holds a valid instruction.
REQ-013 SHALL have port ins  out  32  instruction word at the queue head.
REQ-014 SHALL have port ins_pc  out  32  address of the queue head.
REQ-015 SHALL have port npc  out  32  ins_pc + 4, modulo 2^32.

Function
REQ-016 SHALL allow at most one outstanding memory request.
REQ-017 SHALL implement states: IDLE (no request), WAIT (request live), DISCARD (request live, response to be dropped).
REQ-018 SHALL keep fetch_pc, the next address to request; each accepted (non-dropped) response advances it by 4, modulo 2^32 with wrap.
REQ-019 SHALL issue a request at an edge, setting im_req=1 and im_addr=fetch_pc, only when no request remains outstanding after that edge and the post-edge queue count is less than DEPTH.
REQ-020 SHALL, in WAIT with im_ack=1 and no redirect: push {im_addr, im_data} at the tail, then either issue back-to-back at im_addr+4 (staying in WAIT) or drop im_req and go to IDLE.
REQ-021 SHALL pop the head at an edge when ins_valid=1, if_bubble=0 and if_pc_jump=0; push and pop in the same cycle leave the count unchanged, including when the queue is full.
REQ-022 SHALL leave the queue and all outputs unchanged while if_bubble=1, except for pushes.
REQ-023 SHALL, on if_pc_jump=1, flush all queue entries so that ins_valid=0 after the edge, and set fetch_pc to jpc.
REQ-024 SHALL respond to a redirect in IDLE by issuing a request to jpc at the same edge.
REQ-025 SHALL respond to a redirect in WAIT with im_ack=0 by keeping im_req and im_addr unchanged and moving to DISCARD.
REQ-026 SHALL respond to a redirect in WAIT or DISCARD with im_ack=1 by dropping im_data and issuing a request to jpc at the same edge, entering WAIT.
REQ-027 SHALL, in DISCARD with im_ack=1 and no redirect, drop im_data and issue a request to fetch_pc, entering WAIT.
REQ-028 SHALL, on a redirect in DISCARD with im_ack=0, update fetch_pc to jpc and remain in DISCARD.
REQ-029 SHALL give if_pc_jump priority over if_bubble.
REQ-030 SHALL drive ins, ins_pc and npc combinationally from the head entry; their values are don't-care when ins_valid=0 except after reset.
REQ-031 SHALL never overflow: a full queue implies no outstanding request.

Reset
REQ-032 SHALL, while rst=0, immediately force im_req=0, im_addr=RESET_PC, ins_valid=0, state IDLE, queue count 0, fetch_pc=RESET_PC, and storage to zero (ins=0, ins_pc=0, npc=4).
REQ-033 SHALL issue the first request to RESET_PC at the first rising edge after rst deasserts.
REQ-034 SHALL discard any response to a request that was in flight when reset asserted.

Verification
REQ-035 SHALL cover: reset release, im_ack=1 every cycle, im_data=addr, if_bubble=0 -> im_addr sequence 0,4,8,C,... one per cycle; ins_valid=1 from the third edge; ins_pc increments by 4 each cycle.
REQ-036 SHALL cover: if_bubble=1 held, im_ack=1 -> exactly 4 pushes (pcs 0,4,8,C), then im_req=0; release bubble -> ins_pc 0,4,8,C on consecutive cycles and fetching resumes at 0x10.
REQ-037 SHALL cover: request to 0x10 pending, im_ack held 0 for 3 cycles, if_pc_jump with jpc=0x100 -> ins_valid=0, im_addr stays 0x10 until ack, that data is dropped, next im_addr=0x100, first valid ins_pc=0x100.
REQ-038 SHALL cover: if_pc_jump with jpc=0x200 coincident with im_ack -> ack data not queued, im_addr=0x200 and im_req=1 after the edge.
REQ-039 SHALL cover: rst pulsed low mid-WAIT with the queue holding 2 entries -> im_req=0 and ins_valid=0 without a clock edge; after release, first im_addr=RESET_PC.
REQ-040 SHALL cover: queue full with if_bubble=0 and im_ack=1 each cycle -> count stays DEPTH-1 or DEPTH, ins_pc stays strictly sequential, and no entry is lost or duplicated.
